// File: rtl/div_unit.sv
// Radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU); XLEN+1 busy cycles, zero for divide-by-zero/overflow.
// Stalls the pipeline via div_busy; holds div_result in DONE until ex_advance, and flush kills the operation at once.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            div_start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            ex_advance,
    input  logic            flush,
    output logic            div_busy,
    output logic            div_done,
    output logic [XLEN-1:0] div_result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   rem_q, quo_q, dvsr_q, result_q;
    logic              neg_q, neg_r, sel_rem;

    logic              is_signed, div_zero, overflow, special;
    logic [XLEN-1:0]   special_val, abs1, abs2;
    logic [XLEN:0]     shifted, trial;
    logic [XLEN-1:0]   rem_nx, quo_nx, q_fix, r_fix;

    always_comb begin
        is_signed   = ~div_op[0];
        div_zero    = (rs2 == '0);
        overflow    = is_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        special     = (state == IDLE) && div_start && !flush && (div_zero || overflow);
        // Overflow quotient equals the dividend itself (the most negative value).
        if (div_zero)
            special_val = div_op[1] ? rs1 : '1;
        else
            special_val = div_op[1] ? '0 : rs1;
        abs1 = (is_signed && rs1[XLEN-1]) ? -rs1 : rs1;
        abs2 = (is_signed && rs2[XLEN-1]) ? -rs2 : rs2;
    end

    // One restoring step: shift {rem, quo} left, keep the trial difference when non-negative.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, dvsr_q};
        if (!trial[XLEN]) begin
            rem_nx = trial[XLEN-1:0];
            quo_nx = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nx = shifted[XLEN-1:0];
            quo_nx = {quo_q[XLEN-2:0], 1'b0};
        end
        q_fix = neg_q ? -quo_nx : quo_nx;
        r_fix = neg_r ? -rem_nx : rem_nx;
    end

    // div_busy must not depend on ex_advance: the controller derives its EX/MEM enable from it.
    always_comb begin
        div_busy   = !flush && ((state == BUSY) ||
                                ((state == IDLE) && div_start && !(div_zero || overflow)));
        div_done   = !flush && ((state == DONE) || special);
        div_result = special ? special_val : result_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            sel_rem  <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start && !div_zero && !overflow) begin
                        rem_q   <= '0;
                        quo_q   <= abs1;
                        dvsr_q  <= abs2;
                        neg_q   <= is_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                        neg_r   <= is_signed && rs1[XLEN-1];
                        sel_rem <= div_op[1];
                        cnt     <= CNT_W'(XLEN-1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result_q <= sel_rem ? r_fix : q_fix;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (ex_advance)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed plan cases plus randomized operations against an arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        div_start = 1'b0;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        ex_advance = 1'b0;
    logic        flush = 1'b0;
    logic        div_busy, div_done;
    logic [31:0] div_result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_unit #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .div_start(div_start), .div_op(div_op),
        .rs1(rs1), .rs2(rs2), .ex_advance(ex_advance), .flush(flush),
        .div_busy(div_busy), .div_done(div_done), .div_result(div_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RISC-V division semantics straight from the ISA rules.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = '1; r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0;
        end else if (!op[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    // Monitor: the instruction's result is consumed when it leaves EX.
    always @(negedge clk) begin
        if (reset_n && div_done && ex_advance) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %h with empty scoreboard", div_result);
            end else begin
                chk("result", div_result, exp_q.pop_front());
            end
        end
    end

    // Entered at posedge+#1; leaves at posedge+#1 with the instruction gone from EX.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold);
        int busy_cnt = 0;
        int done_cyc = -1;
        int exp_busy;
        logic [31:0] first_res;
        exp_busy = (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : 33;
        exp_q.push_back(exp);
        div_start = 1'b1; div_op = op; rs1 = a; rs2 = b;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (div_busy) busy_cnt++;
            if (div_done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (done_cyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no div_done, expected one within 100 cycles");
            void'(exp_q.pop_back());
            @(posedge clk); #1;
            div_start = 1'b0;
            return;
        end
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("done_cycle", done_cyc, exp_busy);
        first_res = div_result;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_done", div_done, 1'b1);
            chk("hold_busy", div_busy, 1'b0);
            chk("hold_result", div_result, first_res);
        end
        @(posedge clk); #1;
        ex_advance = 1'b1;
        @(posedge clk); #1;
        ex_advance = 1'b0;
        div_start  = 1'b0;
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;

        #3;
        chk("reset_busy", div_busy, 1'b0);
        chk("reset_done", div_done, 1'b0);
        chk("reset_result", div_result, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(OP_DIV,  32'd100, 32'd7, 32'd14, 0);
        run_op(OP_REM,  32'd100, 32'd7, 32'd2, 0);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0);
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'd1, 32'h0, 0);
        run_op(OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op(OP_REM,  32'd5, 32'd0, 32'd5, 0);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);

        // Result held in DONE, then an immediate back-to-back divide.
        run_op(OP_DIV, 32'd1000, 32'd7, 32'd142, 4);
        run_op(OP_DIV, 32'd9, 32'd3, 32'd3, 0);

        // Flush on the 10th BUSY cycle.
        div_start = 1'b1; div_op = OP_DIV; rs1 = 32'd12345; rs2 = 32'd11;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy", div_busy, 1'b0);
        chk("flush_done", div_done, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; div_start = 1'b0;
        @(negedge clk);
        chk("post_flush_busy", div_busy, 1'b0);
        chk("post_flush_done", div_done, 1'b0);
        @(posedge clk); #1;
        run_op(OP_DIVU, 32'd20, 32'd6, 32'd3, 0);

        // Reset on the 5th BUSY cycle.
        div_start = 1'b1; div_op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0; div_start = 1'b0;
        #1;
        chk("midreset_busy", div_busy, 1'b0);
        chk("midreset_done", div_done, 1'b0);
        chk("midreset_result", div_result, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_reset_busy", div_busy, 1'b0);
        chk("post_reset_done", div_done, 1'b0);
        @(posedge clk); #1;
        run_op(OP_REMU, 32'd1000, 32'd3, 32'd1, 0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = 32'h0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 500); b = $urandom_range(1, 20); end
                3: begin a = $urandom; b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            run_op(op, a, b, model(op, a, b), (i % 7 == 0) ? 2 : 0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divider in the EX stage; sole producer of the div_busy stall that the pipeline controller consumes.
- While busy, the pipeline controller freezes IF/ID, ID/EX and EX/MEM and bubbles MEM/WB.
- Implements DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, one quotient bit per cycle.
- Presents a registered result in a DONE cycle and holds it until the EX stage advances.

Parameters:
- XLEN, 32: operand and result width.
- CNT_W, $clog2(XLEN): width of the iteration counter.

Ports:
- clk  input  1  core clock.
- reset_n  input  1  asynchronous active-low reset.
- div_start  input  1  a valid divide instruction is in EX; held high while the instruction stays in EX.
- div_op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1  input  XLEN  dividend.
- rs2  input  XLEN  divisor.
- ex_advance  input  1  EX/MEM register enable this cycle, i.e. the instruction leaves EX.
- flush  input  1  kill the instruction in EX (branch_hazard, trap or trap_ret).
- div_busy  output  1  stall request to the pipeline controller.
- div_done  output  1  div_result is valid for the instruction in EX.
- div_result  output  XLEN  quotient or remainder.

Behaviour:
- Reset (asynchronous, reset_n low):
  - State goes to IDLE, counter to 0, all datapath registers to 0.
  - div_busy=0, div_done=0, div_result=0.
  - Reset mid-operation abandons the operation with no residue.
- States: IDLE, BUSY, DONE.
- IDLE, div_start=1, flush=0, no special case:
  - div_busy=1 combinationally in this same cycle.
  - Latch |rs1| and |rs2|; absolute values apply only for DIV/REM, otherwise raw.
  - Latch the sign fixups: quotient sign = rs1[31]^rs2[31]; remainder sign = rs1[31].
  - Clear the partial remainder, set counter=XLEN-1, go to BUSY.
- IDLE special cases (combinational, div_busy=0, div_done=1, no state change):
  - Divide by zero (rs2=0):
    - Quotient = all-ones.
    - Remainder = rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF):
    - Quotient = 0x80000000.
    - Remainder = 0.
- BUSY:
  - div_busy=1, div_done=0.
  - Each cycle:
    - Shift {rem, quo} left by 1.
    - Trial-subtract the divisor on XLEN+1 bits.
    - Keep the result if non-negative and set the quotient LSB to 1; otherwise set it to 0.
  - Decrement the counter each cycle.
  - At counter=0, apply the sign fixup, register div_result (selected by div_op[1]) and go to DONE.
- DONE:
  - div_busy=0, div_done=1, div_result stable.
  - Go to IDLE when ex_advance=1; otherwise stay in DONE.
  - div_start is ignored in DONE, so a held instruction is never re-executed.
- Latency, nominal case: div_busy is high for exactly XLEN+1 cycles (start cycle plus XLEN iterations); the result is valid in cycle XLEN+1.
- Back-to-back divides: the following divide enters EX in the cycle after DONE and starts from IDLE normally.
- flush:
  - Highest priority after reset.
  - In any state it forces div_busy=0 and div_done=0 combinationally.
  - Next state is IDLE.
  - flush in the same cycle as div_start in IDLE does not start an operation.
- Combinational-path rule: div_busy depends only on state, div_start, div_op, rs1, rs2 and flush, never on ex_advance. This prevents a loop through the controller's exe_mem_reg_en.
- div_done is not asserted in IDLE unless a special case applies.

Test Plan:
- DIV 100/7:
  - div_busy high for 33 consecutive cycles starting with the start cycle.
  - Next cycle: div_done=1, div_result=14.
  - Repeat as REM: div_result=2.
- Signed case -7/2 (0xFFFFFFF9, 0x00000002):
  - DIV gives 0xFFFFFFFD.
  - REM gives 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF/1 gives 0xFFFFFFFF.
  - REMU 0xFFFFFFFF/1 gives 0.
- Special cases, each with div_busy never asserted and div_done=1 in the start cycle:
  - DIV 5/0 gives 0xFFFFFFFF.
  - REM 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM 0x80000000/0xFFFFFFFF gives 0.
- DONE held:
  - With ex_advance=0 for 4 cycles after completion, div_done stays 1, div_result stays stable and no restart occurs.
  - ex_advance=1 then returns to IDLE.
  - An immediate second DIV 9/3 yields 3 after another 33 busy cycles.
- Flush:
  - flush on the 10th BUSY cycle drops div_busy that cycle; IDLE next cycle.
  - A new DIVU 20/6 then gives 3 with full latency.
- Reset:
  - reset_n low on the 5th BUSY cycle immediately clears div_busy, div_done and div_result.
  - After release, the unit is in IDLE and accepts a new operation.
